// File: rtl/z_sca_pkg.sv
// Shared constants, stage-count helper and payload type for the segmented
// carry-select adder family.
package z_sca_pkg;

  localparam int SCA_WIDTH = 32;
  localparam int SCA_SEG   = 8;

  function automatic int z_sca_nseg(input int width, input int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction

  // Stage payload at the default configuration; wider/narrower builds size
  // their per-stage registers from WIDTH/SEG directly.
  typedef struct packed {
    logic                 vld;
    logic [SCA_WIDTH-1:0] sum;
    logic [SCA_WIDTH-1:0] a;
    logic [SCA_WIDTH-1:0] b;
    logic                 cy;
    logic                 sub;
  } sca_stage_t;

endpackage

// File: rtl/z_sca_seg.sv
// Combinational SEG-bit carry-select segment. With Z_SCA_STATUS_EN defined it
// also reports the carry into its MSB for signed-overflow detection.
module z_sca_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
`ifdef Z_SCA_STATUS_EN
  output logic           c_msb,
`endif
  output logic           cout
);

  logic [SEG:0] sum0;
  logic [SEG:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};

  assign {cout, sum} = cin ? sum1 : sum0;

`ifdef Z_SCA_STATUS_EN
  assign c_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
`endif

endmodule

// File: rtl/z_pipe_sca_adder.sv
// Pipelined segmented carry-select adder/subtractor, one stage per SEG-bit
// segment. Define Z_SCA_STATUS_EN to enable the out_ovf/out_zero flags.
module z_pipe_sca_adder
  import z_sca_pkg::*;
#(
  parameter int WIDTH = SCA_WIDTH,
  parameter int SEG   = SCA_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSEG = z_sca_nseg(WIDTH, SEG);
  localparam int LAST = NSEG - 1;

  if (SEG < 1) begin : g_bad_seg
    $error("z_pipe_sca_adder: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_bad_width
    $error("z_pipe_sca_adder: WIDTH must be a multiple of SEG");
  end

  logic advance;

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int LO  = k * SEG;
    localparam int RIN = WIDTH - LO;

    logic [RIN-1:0]    a_in;
    logic [RIN-1:0]    b_in;
    logic              cy_in;
    logic              vld_in;
    logic [SEG-1:0]    seg_sum;
    logic              seg_cy;
    logic              vld_p;
    logic              cy_p;
    logic [LO+SEG-1:0] sum_p;
`ifdef Z_SCA_STATUS_EN
    logic              seg_cmsb;
`endif

    z_sca_seg #(.SEG(SEG)) u_seg (
      .a     (a_in[SEG-1:0]),
      .b     (b_in[SEG-1:0]),
      .cin   (cy_in),
      .sum   (seg_sum),
`ifdef Z_SCA_STATUS_EN
      .c_msb (seg_cmsb),
`endif
      .cout  (seg_cy)
    );

    // Stage k boundary: operands come from the ports or the previous skew regs
    if (k == 0) begin : g_src
      assign a_in   = in_a;
      assign b_in   = in_sub ? ~in_b : in_b;
      assign cy_in  = in_sub | in_cin;
      assign vld_in = in_valid;

      always_ff @(posedge clk) begin
        if (advance) sum_p <= seg_sum;
      end
    end else begin : g_src
      assign a_in   = stg[k-1].g_rem.a_p;
      assign b_in   = stg[k-1].g_rem.b_p;
      assign cy_in  = stg[k-1].cy_p;
      assign vld_in = stg[k-1].vld_p;

      always_ff @(posedge clk) begin
        if (advance) sum_p <= {seg_sum, stg[k-1].sum_p};
      end
    end

    always_ff @(posedge clk) begin
      if (rst)          vld_p <= 1'b0;
      else if (advance) vld_p <= vld_in;
    end

    always_ff @(posedge clk) begin
      if (advance) cy_p <= seg_cy;
    end

    if (RIN > SEG) begin : g_rem
      logic [RIN-SEG-1:0] a_p;
      logic [RIN-SEG-1:0] b_p;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_p <= a_in[RIN-1:SEG];
          b_p <= b_in[RIN-1:SEG];
        end
      end
    end

`ifdef Z_SCA_STATUS_EN
    if (k == LAST) begin : g_flag
      logic cmsb_p;

      always_ff @(posedge clk) begin
        if (advance) cmsb_p <= seg_cmsb;
      end
    end
`endif
  end

  // Output boundary: results are masked while no valid operation is present
  assign out_valid = stg[LAST].vld_p;
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign out_sum   = out_valid ? stg[LAST].sum_p : '0;
  assign out_cout  = out_valid & stg[LAST].cy_p;

`ifdef Z_SCA_STATUS_EN
  assign out_ovf  = out_valid & (stg[LAST].cy_p ^ stg[LAST].g_flag.cmsb_p);
  assign out_zero = out_valid & (stg[LAST].sum_p == '0);
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_z_pipe_sca_adder.sv
// Directed and randomized bench for z_pipe_sca_adder (32/8 main instance plus
// a parameter sweep of 8/8, 16/4 and 64/16).
module tb_z_pipe_sca_adder;

`ifdef Z_SCA_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;

  logic        sw_valid, sw_cin, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic        r8_rdy, r8_vld, r8_co, r8_ov, r8_z;
  logic [7:0]  r8_sum;
  logic        r16_rdy, r16_vld, r16_co, r16_ov, r16_z;
  logic [15:0] r16_sum;
  logic        r64_rdy, r64_vld, r64_co, r64_ov, r64_z;
  logic [63:0] r64_sum;

  int n_chk = 0;
  int n_pass = 0;

  z_pipe_sca_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  z_pipe_sca_adder #(.WIDTH(8), .SEG(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8_rdy),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(r8_vld), .out_ready(1'b1), .out_sum(r8_sum),
    .out_cout(r8_co), .out_ovf(r8_ov), .out_zero(r8_z)
  );

  z_pipe_sca_adder #(.WIDTH(16), .SEG(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r16_rdy),
    .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(r16_vld), .out_ready(1'b1), .out_sum(r16_sum),
    .out_cout(r16_co), .out_ovf(r16_ov), .out_zero(r16_z)
  );

  z_pipe_sca_adder #(.WIDTH(64), .SEG(16)) u64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r64_rdy),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(r64_vld), .out_ready(1'b1), .out_sum(r64_sum),
    .out_cout(r64_co), .out_ovf(r64_ov), .out_zero(r64_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flat full-width reference: {ovf, zero, cout, sum[63:0]}
  function automatic logic [66:0] mdl(input int w, input logic [63:0] a,
                                      input logic [63:0] b, input logic cin,
                                      input logic sub);
    logic [64:0] m, aa, bb, s;
    logic co, cm;
    m  = (65'd1 << w) - 65'd1;
    aa = {1'b0, a} & m;
    bb = {1'b0, (sub ? ~b : b)} & m;
    s  = aa + bb + (sub ? 65'd1 : {64'd0, cin});
    co = s[w];
    cm = s[w-1] ^ aa[w-1] ^ bb[w-1];
    s  = s & m;
    return {co ^ cm, (s == 65'd0), co, s[63:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (out_sum !== 32'd0) $display("FAIL reset_sum got=%h exp=0", out_sum); else n_pass++;
    n_chk++; if (out_cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", out_cout); else n_pass++;
    n_chk++; if (out_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", out_ovf); else n_pass++;
    n_chk++; if (out_zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", out_zero); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[6];
    int lat;
    logic [31:0] s;
    logic co, ov, z;
    v[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    v[1] = '{32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    v[2] = '{32'd7,         32'd5,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    v[3] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    v[4] = '{32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    v[5] = '{32'd5,         32'd5,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_a = v[i].a; in_b = v[i].b; in_cin = v[i].cin; in_sub = v[i].sub;
      in_valid = 1'b1; out_ready = 1'b1;
      lat = 0; s = 'x; co = 'x; ov = 'x; z = 'x;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) in_valid = 1'b0;
        if (out_valid === 1'b1 && lat == 0) begin
          lat = k; s = out_sum; co = out_cout; ov = out_ovf; z = out_zero;
        end
      end
      n_chk++; if (lat != 4) $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); else n_pass++;
      n_chk++; if (s !== v[i].s) $display("FAIL dir%0d_sum got=%h exp=%h", i, s, v[i].s); else n_pass++;
      n_chk++; if (co !== v[i].co) $display("FAIL dir%0d_cout got=%b exp=%b", i, co, v[i].co); else n_pass++;
      n_chk++; if (ov !== (v[i].ov & ST)) $display("FAIL dir%0d_ovf got=%b exp=%b", i, ov, v[i].ov & ST); else n_pass++;
      n_chk++; if (z !== (v[i].z & ST)) $display("FAIL dir%0d_zero got=%b exp=%b", i, z, v[i].z & ST); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [66:0] q[$];
    logic [66:0] e;
    logic [34:0] held, expv;
    logic prev_stall, have;
    int acc, drained, guard;
    acc = 0; drained = 0; guard = 0; prev_stall = 1'b0; have = 1'b0; held = '0;
    while ((acc < 1000 || q.size() > 0) && guard < 6000) begin
      @(negedge clk);
      guard++;
      if (prev_stall) begin
        n_chk++;
        if (out_valid !== 1'b1 || {out_ovf, out_zero, out_cout, out_sum} !== held)
          $display("FAIL stall_hold got=%b/%h exp=1/%h", out_valid, {out_ovf, out_zero, out_cout, out_sum}, held);
        else n_pass++;
      end
      out_ready = ($urandom_range(0, 9) >= 3);
      if (acc < 1000) begin
        if (!have) begin
          in_a = $urandom;
          in_b = ($urandom_range(0, 7) == 0) ? ~in_a : $urandom;
          in_cin = $urandom_range(0, 1);
          in_sub = $urandom_range(0, 1);
          have = 1'b1;
        end
        in_valid = ($urandom_range(0, 9) != 0);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_chk++;
      if (in_ready !== (!out_valid || out_ready))
        $display("FAIL in_ready got=%b exp=%b", in_ready, (!out_valid || out_ready));
      else n_pass++;
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL b2b_spurious got=%h exp=none", out_sum);
        end else begin
          e = q.pop_front();
          expv = {e[66] & ST, e[65] & ST, e[64], e[31:0]};
          if ({out_ovf, out_zero, out_cout, out_sum} !== expv)
            $display("FAIL b2b_result%0d got=%h exp=%h", drained, {out_ovf, out_zero, out_cout, out_sum}, expv);
          else n_pass++;
        end
        drained++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      held = {out_ovf, out_zero, out_cout, out_sum};
      if (in_valid && in_ready) begin
        q.push_back(mdl(32, {32'd0, in_a}, {32'd0, in_b}, in_cin, in_sub));
        acc++;
        have = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_chk++; if (drained != 1000 || q.size() != 0) $display("FAIL b2b_count got=%0d exp=1000 (left %0d)", drained, q.size()); else n_pass++;
  endtask

  task automatic test_reset_flight();
    int cnt, lat;
    logic [31:0] s;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = 32'h100 + i; in_b = 32'h1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; in_a = 32'hDEAD_0000; in_valid = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if ({out_sum, out_cout, out_ovf, out_zero} !== 35'd0) $display("FAIL flush_outputs got=%h exp=0", {out_sum, out_cout, out_ovf, out_zero}); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", in_ready); else n_pass++;
    rst = 1'b0;
    in_a = 32'h0000_1234; in_b = 32'h0000_1111; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    cnt = 0; lat = 0; s = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        cnt++;
        if (lat == 0) begin lat = k; s = out_sum; end
      end
    end
    n_chk++; if (cnt != 1) $display("FAIL flush_alone got=%0d exp=1", cnt); else n_pass++;
    n_chk++; if (lat != 4) $display("FAIL flush_latency got=%0d exp=4", lat); else n_pass++;
    n_chk++; if (s !== 32'h0000_2345) $display("FAIL flush_sum got=%h exp=00002345", s); else n_pass++;
  endtask

  task automatic test_sweep();
    logic [66:0] e8, e16, e64;
    logic [66:0] g8, g16, g64;
    int l8, l16, l64;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++; if ({r8_rdy, r16_rdy, r64_rdy} !== 3'b111) $display("FAIL sweep_ready got=%b exp=111", {r8_rdy, r16_rdy, r64_rdy}); else n_pass++;
      if (i == 0) begin
        sw_a = 64'h7FFF_FFFF_FFFF_FF7F; sw_b = 64'h0000_0000_0000_0001; sw_cin = 1'b0; sw_sub = 1'b0;
      end else begin
        sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
        sw_cin = $urandom_range(0, 1); sw_sub = $urandom_range(0, 1);
      end
      sw_valid = 1'b1;
      e8 = mdl(8, sw_a, sw_b, sw_cin, sw_sub);
      e16 = mdl(16, sw_a, sw_b, sw_cin, sw_sub);
      e64 = mdl(64, sw_a, sw_b, sw_cin, sw_sub);
      l8 = 0; l16 = 0; l64 = 0; g8 = 'x; g16 = 'x; g64 = 'x;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) sw_valid = 1'b0;
        if (r8_vld === 1'b1 && l8 == 0) begin l8 = k; g8 = {r8_ov, r8_z, r8_co, 56'd0, r8_sum}; end
        if (r16_vld === 1'b1 && l16 == 0) begin l16 = k; g16 = {r16_ov, r16_z, r16_co, 48'd0, r16_sum}; end
        if (r64_vld === 1'b1 && l64 == 0) begin l64 = k; g64 = {r64_ov, r64_z, r64_co, r64_sum}; end
      end
      e8  = {e8[66] & ST, e8[65] & ST, e8[64:0]};
      e16 = {e16[66] & ST, e16[65] & ST, e16[64:0]};
      e64 = {e64[66] & ST, e64[65] & ST, e64[64:0]};
      n_chk++; if (l8 != 1) $display("FAIL sw8_latency got=%0d exp=1", l8); else n_pass++;
      n_chk++; if (l16 != 4) $display("FAIL sw16_latency got=%0d exp=4", l16); else n_pass++;
      n_chk++; if (l64 != 4) $display("FAIL sw64_latency got=%0d exp=4", l64); else n_pass++;
      n_chk++; if (g8 !== e8) $display("FAIL sw8_result%0d got=%h exp=%h", i, g8, e8); else n_pass++;
      n_chk++; if (g16 !== e16) $display("FAIL sw16_result%0d got=%h exp=%h", i, g16, e16); else n_pass++;
      n_chk++; if (g64 !== e64) $display("FAIL sw64_result%0d got=%h exp=%h", i, g64, e64); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flight();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/z_pipe_sca_adder.md
# z_pipe_sca_adder

Parametrised, pipelined segmented carry-select adder/subtractor. A WIDTH-bit operation is split into NSEG = WIDTH/SEG segments of SEG bits, one pipeline stage per segment, with the carry registered between stages. Accepts one operation per cycle under a valid/ready handshake and returns results in order after NSEG cycles. Serves as the wide arithmetic datapath in the adder family; designed for high clock rates where a flat ripple or carry-select chain cannot close timing.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG
- SEG, 8, bits per segment (one pipeline stage each); SEG ≥ 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in; ignored when in_sub=1
- in_sub  in  1  0: A+B+cin; 1: A−B, computed as A+~B+1
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  out  1  two's-complement signed overflow
- out_zero  out  1  out_sum == 0

## Operation
- Stage k (0..NSEG−1) adds segment k of A and B′ (B′ = in_sub ? ~B : B) using the carry registered by stage k−1; stage 0 uses in_sub ? 1 : in_cin.
- Each segment is carry-select: both SEG-bit sums for carry 0 and carry 1 are computed, and the incoming carry selects one.
- Operand segments not yet consumed travel forward in skew registers; completed sum segments travel forward in deskew registers. The final stage presents the full WIDTH-bit sum.
- Pipeline control: advance = !(out_valid && !out_ready). All stage registers, including the valid bits, load only when advance=1. in_ready = advance.
- A bubble (in_valid=0 while advancing) propagates as valid=0. Results leave in the order accepted, with no loss or duplication.
- out_ovf = carry into MSB XOR carry out of MSB. out_zero is computed from the final assembled sum.
- Illegal parameters (WIDTH % SEG ≠ 0, SEG < 1) stop elaboration with an error.

## Timing
- Latency: an operation accepted at edge t has out_valid=1 after edge t+NSEG, provided there is no stall. Throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, every register holds and out_* stay stable. in_ready=0 in the same cycle, combinationally.
- A simultaneous accept and output drain in one cycle is legal and does not create a bubble.
- Reset: the rst sampled high at an edge clears every valid bit. Next cycle: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, in_ready=1. In-flight operations are discarded; no stale result ever appears.
- Reset takes priority over advance and over in_valid in the same cycle.
- NSEG=1 degenerates to one registered carry-select adder with latency 1.

## Configuration
- Z_SCA_STATUS_EN defined: out_ovf and out_zero are computed as in Operation. The MSB carry-in is registered alongside the final stage.
- Z_SCA_STATUS_EN undefined: out_ovf and out_zero ports remain but are tied 0, and the extra flag logic and registers are removed. Sum, cout and handshake behaviour are unchanged.

## Structure
- Shared package z_sca_pkg holds:
  - the default WIDTH/SEG constants;
  - a function computing NSEG;
  - the stage payload struct type: valid, partial sum, remaining A/B′, carry, sub flag.
- Sub-module z_sca_seg: a combinational SEG-bit carry-select segment (a, b, cin → sum, cout, plus the carry into its MSB for the flags). It is instantiated once per stage in a generate loop.

## Test plan
- WIDTH=32, SEG=8, add, a=0x0000_0001, b=0xFFFF_FFFF, cin=0 → 4 cycles later sum=0x0000_0000, cout=1, zero=1, ovf=0.
- Subtract, a=5, b=7 → sum=0xFFFF_FFFE, cout=0, ovf=0, zero=0; subtract a=7, b=5 → sum=2, cout=1.
- Add, a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, ovf=1 (ovf=0 with Z_SCA_STATUS_EN undefined); add a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1.
- 1000 random back-to-back ops with out_ready randomly low about 30% of the time → in-order results matching a golden model, out_* stable during stalls, in_ready low exactly while stalled.
- Three ops in flight, rst pulsed for 1 cycle → next cycle out_valid=0 and all outputs 0; the next op accepted after reset emerges alone 4 cycles later.
- Parameter sweep, with (WIDTH,SEG) = (8,8), (16,4), (64,16) → latency equals NSEG and random results match the model.
